nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Multi-precision adder sequencer. It accepts WIDTH-bit operands over a valid/ready handshake and computes the sum one nibble per cycle. The arithmetic runs on a single internal `ripple_carry_adder_4bit` instance, with a registered carry chained between nibbles. It lets wide additions share one 4-bit adder datapath instead of replicating it, trading latency for area.

## Interface
- WIDTH, default 16: operand/result width in bits; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into nibble 0.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, a + b + cin mod 2^WIDTH.
- cout  output  1  carry out of the most significant nibble.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready:
    - Capture a, b and cin into a_r, b_r and carry_r.
    - Clear idx to 0.
    - Go to RUN.
- **RUN**
  - in_ready = 0.
  - The adder takes a_r[4·idx+3:4·idx], b_r[4·idx+3:4·idx] and carry_r.
  - At each edge:
    - sum[4·idx+3:4·idx] ← adder Sum.
    - carry_r ← adder Cout.
    - idx ← idx+1.
  - When idx == NIB−1 at the edge:
    - cout ← adder Cout.
    - Go to DONE; do not increment idx.
- **DONE**
  - out_valid = 1.
  - sum and cout are held stable.
  - On out_ready, go to IDLE.
  - There is no same-cycle accept of a new request in DONE.
- idx is a counter of width max(1, clog2(NIB)). It never wraps past NIB−1.
- Arithmetic rules:
  - Result is unsigned, modulo 2^WIDTH.
  - Overflow is reported only via cout.
  - No saturation.
- Input changes after the accept edge are ignored, because operands are registered.
- in_valid outside IDLE is ignored. No request is queued.
- sum and cout keep the last result after DONE exits.
  - The sum nibbles are overwritten progressively during the next RUN.
  - Their values are meaningful only while out_valid = 1.
- Asynchronous reset (rst_n low), at any time including mid-RUN or in DONE:
  - State returns to IDLE.
  - idx, carry_r, a_r, b_r, sum and cout are cleared to 0.
  - out_valid = 0. Any in-flight operation is discarded without producing out_valid.
- When NIB = 1, RUN lasts exactly one cycle.

## Timing
- Reset values:
  - in_ready = 1 and busy = 0 (state is IDLE).
  - out_valid = 0.
  - sum = 0 and cout = 0.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Accept handshake at edge T:
  - RUN occupies the cycles between edges T and T+NIB.
  - out_valid rises after edge T+NIB.
  - Latency is NIB cycles.
- With out_ready held high:
  - DONE lasts 1 cycle and in_ready returns after edge T+NIB+1.
  - The next accept can occur at edge T+NIB+2.
  - Peak throughput is one operation per NIB+2 cycles.
- When out_ready is low, DONE persists indefinitely. out_valid, sum and cout must not change during that time.
- The critical path is one 4-bit ripple plus the operand nibble mux.

## Test plan
- **Reset:** assert rst_n low with random inputs toggling → in_ready=1, busy=0, out_valid=0, sum=0x0000, cout=0. Release reset → no spurious out_valid.
- **Basic add, WIDTH=16:** a=0x1234, b=0x4321, cin=0, out_ready=1.
  - out_valid high exactly 4 cycles after accept.
  - sum=0x5555, cout=0.
  - in_ready back high one cycle after DONE.
- **Full carry ripple:** a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- **Backpressure:** complete 0x00F0 + 0x0010 with out_ready held low 5 cycles.
  - sum=0x0100, cout=0, both stable throughout.
  - out_valid stays high and in_ready stays 0.
  - in_valid pulses with other operands are ignored.
  - After out_ready rises, the next op 0x0001 + 0x0001 gives 0x0002.
- **Reset mid-operation:** start 0x8888 + 0x8888, then drive rst_n low after 2 RUN cycles.
  - Outputs clear immediately (asynchronously).
  - No out_valid is produced.
  - A subsequent 0x8888 + 0x8888 gives sum=0x1110, cout=1.
- **Back-to-back and parameter sweep:** issue 1000 random requests with random out_ready stalls for WIDTH=4, 16 and 32.
  - Each result equals the reference a+b+cin.
  - Accept-to-accept spacing is ≥ NIB+2 cycles.
  - No request is lost or duplicated.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision adder sequencer: adds two WIDTH-bit operands one nibble per
// cycle through a single 4-bit ripple-carry adder, chaining a registered carry
// between nibbles. Operands arrive and results leave over valid/ready handshakes.

// Plain 4-bit ripple-carry adder; the only arithmetic datapath in the block.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    // Ripple the carry bit by bit through four full adders.
    always_comb begin
        // NOTE: every variable gets a default at the top of a combinational block so no path can leave it unassigned and infer a latch.
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last_nib;

    // Operand nibble mux feeding the shared adder; idx selects the current slice.
    assign nib_a    = a_r[4*idx +: 4];
    assign nib_b    = b_r[4*idx +: 4];
    assign last_nib = (idx == IW'(NIB - 1));

    ripple_carry_adder_4bit u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_r),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, whatever the block order.
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, walk the nibbles in RUN, hold in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs, decoded purely from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands on accept, then write one sum nibble per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: result and operand registers are cleared on reset because sum/cout are visible outputs with defined reset values.
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_r[4*idx +: 4] <= nib_sum;
                    carry_r           <= nib_cout;
                    if (last_nib) begin
                        cout_r <= nib_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed vectors and corner
// sequences on a 16-bit instance, plus randomized handshake traffic against an
// arithmetic reference model on 4-, 16- and 32-bit instances.
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Directed 16-bit instance ----------------
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, let it be accepted, then scramble the inputs.
    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".sum"}, sum, 0);
        check({tag, ".cout"}, cout, 0);
    endtask

    bit directed_done = 1'b0;

    initial begin
        int lat;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};

        // Reset with inputs toggling.
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            check_reset_outputs("reset");
        end
        in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset.out_valid", out_valid, 0);
        end

        // Table-driven adds with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vc);
            check($sformatf("vec%0d.busy", i), busy, 1);
            wait_done(lat);
            check($sformatf("vec%0d.latency", i), lat, 4);
            check($sformatf("vec%0d.sum", i), sum, vecs[i].exp_sum);
            check($sformatf("vec%0d.cout", i), cout, vecs[i].exp_cout);
            check($sformatf("vec%0d.in_ready_done", i), in_ready, 0);
            tick();
            check($sformatf("vec%0d.in_ready_back", i), in_ready, 1);
            check($sformatf("vec%0d.out_valid_drop", i), out_valid, 0);
        end

        // Backpressure: result held while out_ready low, extra requests ignored.
        out_ready = 1'b0;
        start_op(16'h00F0, 16'h0010, 1'b0);
        wait_done(lat);
        check("bp.latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'b1;
            check("bp.sum", sum, 16'h0100);
            check("bp.cout", cout, 0);
            check("bp.out_valid", out_valid, 1);
            check("bp.in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        check("bp.sum_end", sum, 16'h0100);
        out_ready = 1'b1;
        tick();
        check("bp.released", in_ready, 1);
        check("bp.no_second_result", out_valid, 0);
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done(lat);
        check("bp.next.latency", lat, 4);
        check("bp.next.sum", sum, 16'h0002);
        check("bp.next.cout", cout, 0);
        tick();

        // Reset in the middle of RUN: async clear, nothing delivered.
        start_op(16'h8888, 16'h8888, 1'b0);
        tick();
        tick();
        check("midrst.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst.no_out_valid", out_valid, 0);
        end
        start_op(16'h8888, 16'h8888, 1'b0);
        wait_done(lat);
        check("midrst.next.latency", lat, 4);
        check("midrst.next.sum", sum, 16'h1110);
        check("midrst.next.cout", cout, 1);
        tick();

        directed_done = 1'b1;
    end

    // ---------------- Randomized sweep over WIDTH ----------------
    logic rst_n_s;
    bit   sweep_done [3];

    initial begin
        rst_n_s = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n_s = 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W   = (g == 0) ? 4 : (g == 1) ? 16 : 32;
        localparam int N   = W / 4;
        localparam int NOP = 1000;

        logic         s_in_valid;
        logic         s_in_ready;
        logic [W-1:0] s_a;
        logic [W-1:0] s_b;
        logic         s_cin;
        logic         s_out_valid;
        logic         s_out_ready;
        logic [W-1:0] s_sum;
        logic         s_cout;
        logic         s_busy;

        nibble_serial_adder_ctrl #(.WIDTH(W)) dut_s (
            .clk       (clk),
            .rst_n     (rst_n_s),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_cin),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .sum       (s_sum),
            .cout      (s_cout),
            .busy      (s_busy)
        );

        logic [W:0] expq[$];

        initial begin
            int  issued    = 0;
            int  delivered = 0;
            int  cyc       = 0;
            int  last_acc  = -1000;
            bit  acc;
            bit  dlv;
            logic [W:0] exp_v;
            s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_out_ready = 1'b0;
            wait (rst_n_s === 1'b1);
            while (delivered < NOP && cyc < 40000) begin
                @(negedge clk);
                acc = s_in_valid && s_in_ready;
                dlv = s_out_valid && s_out_ready;
                if (dlv) begin
                    if (expq.size() == 0) begin
                        check($sformatf("sweep%0d.spurious_result", W), 1, 0);
                    end else begin
                        exp_v = expq.pop_front();
                        check($sformatf("sweep%0d.sum", W), 64'(s_sum), 64'(exp_v[W-1:0]));
                        check($sformatf("sweep%0d.cout", W), s_cout, exp_v[W]);
                    end
                    delivered++;
                end
                if (acc) begin
                    check($sformatf("sweep%0d.no_queueing", W), expq.size(), 0);
                    check($sformatf("sweep%0d.spacing_ok", W), (cyc - last_acc) >= N + 2, 1);
                    expq.push_back({1'b0, s_a} + {1'b0, s_b} + (W+1)'(s_cin));
                    last_acc = cyc;
                    issued++;
                end
                @(posedge clk);
                #1;
                cyc++;
                if (!s_in_valid || acc) begin
                    s_in_valid = (issued < NOP) && ($urandom_range(0, 3) != 0);
                    s_a        = W'($urandom);
                    s_b        = W'($urandom);
                    s_cin      = 1'($urandom);
                end
                s_out_ready = ($urandom_range(0, 3) != 0);
            end
            check($sformatf("sweep%0d.issued", W), issued, NOP);
            check($sformatf("sweep%0d.delivered", W), delivered, NOP);
            s_in_valid = 1'b0;
            sweep_done[g] = 1'b1;
        end
    end

    // Summary once every stream has finished.
    initial begin
        wait (directed_done && sweep_done[0] && sweep_done[1] && sweep_done[2]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
